// File: rtl/arcade_input_pkg.sv
// Shared bit positions, ioctl index and the DB-to-joystick remap used by
// the arcade player-input front end.
package arcade_input_pkg;

    localparam int JB_RIGHT  = 0;
    localparam int JB_LEFT   = 1;
    localparam int JB_DOWN   = 2;
    localparam int JB_UP     = 3;
    localparam int JB_F1     = 4;
    localparam int JB_F2     = 5;
    localparam int JB_F3     = 6;
    localparam int JB_F4     = 7;
    localparam int JB_F5     = 8;
    localparam int JB_START1 = 9;
    localparam int JB_START2 = 10;
    localparam int JB_COIN   = 11;

    localparam logic [7:0] DIP_IOCTL_INDEX = 8'd254;

    // Odd DB ports wire their start buttons the other way round; db[10]&db[5] is a coin chord.
    function automatic logic [31:0] db_remap(input logic [11:0] db, input logic odd);
        logic [31:0] j;
        j                = '0;
        j[JB_F5:0]       = db[8:0];
        j[JB_START1]     = odd ? db[10] : db[9];
        j[JB_START2]     = odd ? db[9]  : db[10];
        j[JB_COIN]       = db[11] | (db[10] & db[5]);
        return j;
    endfunction

endpackage

// File: rtl/arcade_input_autofire.sv
// Per-player autofire: masked buttons are gated by a phase that toggles every
// AF_RATE frames while any masked button is held.
module arcade_input_autofire
    import arcade_input_pkg::*;
#(
    parameter int AF_RATE = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic [31:0] joy_raw,
    input  logic [31:0] af_mask,
    output logic [31:0] joy_af
);

    logic [3:0] af_cnt_d, af_cnt_q;
    logic       af_phase_d, af_phase_q;
    logic       held;

    // Idle state keeps phase high so a fresh press fires on the very first frame.
    always_comb begin
        held       = |(joy_raw & af_mask);
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
        if (!held) begin
            af_cnt_d   = '0;
            af_phase_d = 1'b1;
        end else if (frame_tick) begin
            if (af_cnt_q == 4'(AF_RATE - 1)) begin
                af_cnt_d   = '0;
                af_phase_d = ~af_phase_q;
            end else begin
                af_cnt_d = af_cnt_q + 4'd1;
            end
        end
        joy_af = (joy_raw & ~af_mask) | (joy_raw & af_mask & {32{af_phase_q}});
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b1;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
        end
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player input front end: DB/USB joystick merge, coin stretching, optional
// autofire (ARCADE_INPUT_AUTOFIRE_EN) and the ioctl-loaded DIP bank.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int PLAYERS   = 2,
    parameter int DIP_BYTES = 8,
    parameter int COIN_HOLD = 3,
    parameter int AF_RATE   = 4
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    frame_tick,
    input  logic [PLAYERS*32-1:0]   joy_usb,
    input  logic [PLAYERS*16-1:0]   joy_db,
    input  logic [2:0]              db_players,
    input  logic [31:0]             af_mask,
    input  logic                    ioctl_wr,
    input  logic [7:0]              ioctl_index,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic [PLAYERS*32-1:0]   joy_out,
    output logic [PLAYERS-1:0]      coin_out,
    output logic [DIP_BYTES*8-1:0]  dip
);

    logic [PLAYERS-1:0][31:0] s1_d, s1_q;
    logic [PLAYERS-1:0][31:0] af_out;
    logic [PLAYERS-1:0][31:0] joy_d, joy_q;
    logic [PLAYERS-1:0][3:0]  hold_cnt_d, hold_cnt_q;
    logic [PLAYERS-1:0]       coin_prev_d, coin_prev_q;
    logic [DIP_BYTES-1:0][7:0] dip_d, dip_q;
    logic [PLAYERS-1:0][3:0]  unused_db_hi;
    int                       db_eff;

    // DB sticks fill the first db_players slots, USB sticks fill the rest in order.
    always_comb begin
        db_eff = (int'(db_players) > PLAYERS) ? PLAYERS : int'(db_players);
        for (int p = 0; p < PLAYERS; p++) begin
            s1_d[p] = '0;
            if (p < db_eff) begin
                s1_d[p] = db_remap(joy_db[16*p +: 12], (p % 2) == 1);
            end else begin
                for (int u = 0; u < PLAYERS; u++) begin
                    if (u + db_eff == p) s1_d[p] = joy_usb[32*u +: 32];
                end
            end
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    for (genvar p = 0; p < PLAYERS; p++) begin : g_af
        arcade_input_autofire #(
            .AF_RATE (AF_RATE)
        ) u_af (
            .clk_sys    (clk_sys),
            .reset_n    (reset_n),
            .frame_tick (frame_tick),
            .joy_raw    (s1_q[p]),
            .af_mask    (af_mask),
            .joy_af     (af_out[p])
        );
    end
`else
    logic unused_af_mask;
    assign unused_af_mask = ^af_mask;
    assign af_out         = s1_q;
`endif

    // A new press reloads the hold even on a frame strobe; countdown only runs once released.
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            coin_prev_d[p] = s1_q[p][JB_COIN];
            hold_cnt_d[p]  = hold_cnt_q[p];
            if (s1_q[p][JB_COIN] && !coin_prev_q[p]) begin
                hold_cnt_d[p] = 4'(COIN_HOLD);
            end else if (frame_tick && !s1_q[p][JB_COIN] && hold_cnt_q[p] != 4'd0) begin
                hold_cnt_d[p] = hold_cnt_q[p] - 4'd1;
            end
            joy_d[p]          = af_out[p];
            joy_d[p][JB_COIN] = s1_q[p][JB_COIN] | (hold_cnt_d[p] != 4'd0);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            s1_q        <= '0;
            coin_prev_q <= '0;
            hold_cnt_q  <= '0;
            joy_q       <= '0;
        end else begin
            s1_q        <= s1_d;
            coin_prev_q <= coin_prev_d;
            hold_cnt_q  <= hold_cnt_d;
            joy_q       <= joy_d;
        end
    end

    // The DIP bank deliberately ignores reset so an OSD reset keeps the loaded settings.
    always_comb begin
        dip_d = dip_q;
        if (ioctl_wr && ioctl_index == DIP_IOCTL_INDEX) begin
            for (int n = 0; n < DIP_BYTES; n++) begin
                if (ioctl_addr == 25'(n)) dip_d[n] = ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        dip_q <= dip_d;
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_out
        assign coin_out[p]     = joy_q[p][JB_COIN];
        assign unused_db_hi[p] = joy_db[16*p+12 +: 4];
    end

    assign joy_out = joy_q;
    assign dip     = dip_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl: table of merge/remap vectors plus
// hand sequences for coin stretching, autofire, reset and the DIP bank.
module tb_arcade_input_ctrl;

    localparam int PLAYERS   = 2;
    localparam int DIP_BYTES = 8;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic                   clk_sys = 1'b0;
    logic                   reset_n;
    logic                   frame_tick;
    logic [PLAYERS*32-1:0]  joy_usb;
    logic [PLAYERS*16-1:0]  joy_db;
    logic [2:0]             db_players;
    logic [31:0]            af_mask;
    logic                   ioctl_wr;
    logic [7:0]             ioctl_index;
    logic [24:0]            ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic [PLAYERS*32-1:0]  joy_out;
    logic [PLAYERS-1:0]     coin_out;
    logic [DIP_BYTES*8-1:0] dip;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] usb;
        logic [31:0] db;
        logic [2:0]  dbp;
        logic [63:0] exp_joy;
        logic [1:0]  exp_coin;
    } vec_t;

    vec_t vecs [7];

    arcade_input_ctrl #(
        .PLAYERS   (PLAYERS),
        .DIP_BYTES (DIP_BYTES),
        .COIN_HOLD (3),
        .AF_RATE   (2)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .joy_usb     (joy_usb),
        .joy_db      (joy_db),
        .db_players  (db_players),
        .af_mask     (af_mask),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .joy_out     (joy_out),
        .coin_out    (coin_out),
        .dip         (dip)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        joy_usb    = v.usb;
        joy_db     = v.db;
        db_players = v.dbp;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic writeDip(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        step(1);
        ioctl_wr    = 1'b0;
    endtask

    initial begin
        logic [63:0] prev_joy;
        logic [1:0]  prev_coin;
        logic [31:0] exp_w;

        vecs[0] = '{64'h0000_0200_0000_0001, 32'h0001_0002, 3'd0, 64'h0000_0200_0000_0001, 2'b00};
        vecs[1] = '{64'h0000_00F0_0000_000F, 32'h0200_0200, 3'd2, 64'h0000_0400_0000_0200, 2'b00};
        vecs[2] = '{64'h0000_0000_0000_0000, 32'h0400_F1FF, 3'd2, 64'h0000_0200_0000_01FF, 2'b00};
        vecs[3] = '{64'h0000_0010_0000_0020, 32'h0001_0002, 3'd7, 64'h0000_0001_0000_0002, 2'b00};
        vecs[4] = '{64'h0000_0080_0000_0040, 32'hFFFF_0030, 3'd1, 64'h0000_0040_0000_0030, 2'b00};
        vecs[5] = '{64'hABCD_0300_1234_5000, 32'h0000_0000, 3'd0, 64'hABCD_0300_1234_5000, 2'b00};
        vecs[6] = '{64'h0000_0000_0000_0008, 32'h0000_0421, 3'd1, 64'h0000_0008_0000_0C21, 2'b01};

        reset_n     = 1'b0;
        frame_tick  = 1'b0;
        joy_usb     = '0;
        joy_db      = '0;
        db_players  = 3'd0;
        af_mask     = '0;
        ioctl_wr    = 1'b0;
        ioctl_index = '0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        step(2);
        checkOutput("reset_joy", joy_out, 64'h0);
        checkOutput("reset_coin", 64'(coin_out), 64'h0);

        for (int n = 0; n < DIP_BYTES; n++) writeDip(8'd254, 25'(n), 8'(8'h10 + n));
        reset_n = 1'b1;
        step(1);
        checkOutput("dip_load_in_reset", dip, 64'h1716_1514_1312_1110);
        writeDip(8'd254, 25'd2, 8'hA5);
        checkOutput("dip_write_addr2", dip, 64'h1716_1514_13A5_1110);
        writeDip(8'd254, 25'd8, 8'hFF);
        checkOutput("dip_addr_out_of_range", dip, 64'h1716_1514_13A5_1110);
        writeDip(8'd253, 25'd3, 8'hFF);
        checkOutput("dip_wrong_index", dip, 64'h1716_1514_13A5_1110);
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        checkOutput("dip_survives_reset", dip, 64'h1716_1514_13A5_1110);

        prev_joy  = 64'h0;
        prev_coin = 2'b00;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            step(1);
            checkOutput($sformatf("vec%0d_latency_joy", i), joy_out, prev_joy);
            step(1);
            checkOutput($sformatf("vec%0d_joy", i), joy_out, vecs[i].exp_joy);
            checkOutput($sformatf("vec%0d_coin", i), 64'(coin_out), 64'(vecs[i].exp_coin));
            prev_joy  = vecs[i].exp_joy;
            prev_coin = vecs[i].exp_coin;
        end

        joy_db = 32'h0000_0021;
        step(2);
        checkOutput("coin_release_hold", 64'(coin_out), 64'h1);
        frame();
        step(1);
        checkOutput("coin_tick1", 64'(coin_out), 64'h1);
        frame();
        step(1);
        checkOutput("coin_tick2", 64'(coin_out), 64'h1);
        frame();
        step(1);
        checkOutput("coin_tick3", 64'(coin_out), 64'h0);
        checkOutput("coin_tick3_joy", joy_out, 64'h0000_0008_0000_0021);

        joy_usb = 64'h0000_0000_0000_0800;
        step(1);
        joy_usb = '0;
        step(2);
        checkOutput("pulse_coin", 64'(coin_out), 64'h2);
        frame();
        step(1);
        checkOutput("pulse_tick1", 64'(coin_out), 64'h2);
        frame();
        step(1);
        checkOutput("pulse_tick2", 64'(coin_out), 64'h2);
        frame();
        step(1);
        checkOutput("pulse_tick3", 64'(coin_out), 64'h0);

        joy_db     = '0;
        db_players = 3'd0;
        af_mask    = 32'h10;
        joy_usb    = 64'h0000_0000_0000_0010;
        step(2);
        checkOutput("af_first_press", joy_out, 64'h10);
        for (int k = 1; k <= 10; k++) begin
            frame();
            step(2);
            exp_w = (!AF_EN || ((k / 2) % 2 == 0)) ? 32'h10 : 32'h0;
            checkOutput($sformatf("af_frame%0d", k), 64'(joy_out[31:0]), 64'(exp_w));
        end
        joy_usb = '0;
        step(2);
        checkOutput("af_release", joy_out, 64'h0);
        joy_usb = 64'h0000_0000_0000_0010;
        step(2);
        checkOutput("af_repress", joy_out, 64'h10);

        joy_usb = 64'h0000_0000_0000_0810;
        step(2);
        frame();
        joy_usb = 64'h0000_0800_0000_0810;
        step(1);
        joy_usb = 64'h0000_0000_0000_0810;
        step(2);
        frame();
        step(2);
        checkOutput("pre_reset_p0", 64'(joy_out[31:0]), AF_EN ? 64'h800 : 64'h810);
        checkOutput("pre_reset_p1", 64'(joy_out[63:32]), 64'h800);
        checkOutput("pre_reset_coin", 64'(coin_out), 64'h3);
        reset_n = 1'b0;
        step(1);
        checkOutput("in_reset_joy", joy_out, 64'h0);
        checkOutput("in_reset_coin", 64'(coin_out), 64'h0);
        step(1);
        reset_n = 1'b1;
        step(2);
        checkOutput("post_reset_joy", joy_out, 64'h0000_0000_0000_0810);
        checkOutput("post_reset_coin", 64'(coin_out), 64'h1);
        joy_usb = 64'h0000_0000_0000_0010;
        step(2);
        checkOutput("fresh_coin_pulse", 64'(coin_out), 64'h1);
        checkOutput("fresh_coin_joy", joy_out, 64'h0000_0000_0000_0810);
        checkOutput("dip_after_all", dip, 64'h1716_1514_13A5_1110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arcade_input_ctrl.md
# arcade_input_ctrl

Parametrised player-input front end for the arcade cores. It sits between `hps_io`/`joy_db9md`/`joy_db15` and the game-specific input byte packing. It merges USB and UserIO (DB) joysticks for `PLAYERS` players and shapes coin pulses to a minimum length. It also applies per-button autofire and holds the DIP-switch bank loaded over ioctl index 254. It generalises the fixed two-player DB/USB merge and `sw[8]` DIP loader used in each core top level.

## Interface

Parameters:

- `PLAYERS`, 2 — number of player channels (1..4).
- `DIP_BYTES`, 8 — DIP bank size in bytes (1..32).
- `COIN_HOLD`, 3 — minimum coin pulse length, in `frame_tick` periods (1..15).
- `AF_RATE`, 4 — autofire half-period, in `frame_tick` periods (1..15).

Ports:

- `clk_sys`  in  1  system clock; all logic is on this clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `frame_tick`  in  1  one-cycle strobe once per video frame (VBlank rising edge).
- `joy_usb`  in  `PLAYERS*32`  USB joystick words; USB stick k is in bits [32k+31:32k].
- `joy_db`  in  `PLAYERS*16`  DB9MD/DB15 words in `joy_db9md`/`joy_db15` layout.
- `db_players`  in  3  number of players taken from DB sources (0..`PLAYERS`).
- `af_mask`  in  32  joystick bits subject to autofire.
- `ioctl_wr`  in  1  ioctl write strobe.
- `ioctl_index`  in  8  ioctl index.
- `ioctl_addr`  in  25  ioctl byte address.
- `ioctl_dout`  in  8  ioctl data.
- `joy_out`  out  `PLAYERS*32`  processed joystick words, codebase bit layout (R L D U F1..F5 S1 S2 CO …).
- `coin_out`  out  `PLAYERS`  stretched coin per player.
- `dip`  out  `DIP_BYTES*8`  DIP bank; byte n is in bits [8n+7:8n].

## Operation

**Source select (stage 1, registered)**

- Player p with p < `db_players` takes DB stick p; otherwise it takes USB stick (p − `db_players`).
- If `db_players` > `PLAYERS`, treat it as `PLAYERS`.
- DB→joy remap:
  - bits [8:0] = db[8:0].
  - bit 11 (coin) = db[11] | (db[10] & db[5]).
  - Even p: bit 9 = db[9], bit 10 = db[10].
  - Odd p: bits 9 and 10 are swapped.
  - Bits [31:12] = 0.

**Coin stretcher (stage 2, per player)**

- `hold_cnt` is 4 bits.
- A rising edge of the stage-1 coin bit loads `COIN_HOLD`.
- On `frame_tick`, while the coin is released and `hold_cnt` ≠ 0, decrement `hold_cnt`.
- A rising edge coinciding with `frame_tick` loads; the load wins.
- `coin_out[p]` = coin held | (`hold_cnt` ≠ 0). `joy_out` bit 11 carries the same value.

**Autofire (stage 2, per player)**

- State: `af_cnt` (4 bits) and `af_phase`.
- While no `af_mask` bit is held: `af_cnt` = 0, `af_phase` = 1.
- While any masked bit is held, on each `frame_tick`:
  - `af_cnt` increments.
  - At `AF_RATE`−1, `af_cnt` wraps to 0 and `af_phase` toggles.
- Masked output bits = raw & `af_phase`; unmasked bits pass through.
- The first press fires immediately.

**DIP bank**

- A write with `ioctl_wr` & `ioctl_index` == 254 & `ioctl_addr` < `DIP_BYTES` stores `ioctl_dout` into byte `ioctl_addr`.
- Writes at other addresses or indices are ignored.
- A write arriving during reset is still accepted.

## Timing

- `joy_out` and `coin_out`: 2-cycle latency from `joy_usb`/`joy_db`/`db_players` changes.
- `dip`: updated 1 cycle after the `ioctl_wr` cycle.
- Reset values:
  - `joy_out` = 0, `coin_out` = 0.
  - `hold_cnt` = 0, `af_cnt` = 0, `af_phase` = 1.
  - The stage-1 coin history is cleared to 0, so a coin held through reset gives an edge when reset is released.
- `dip` is not affected by `reset_n`. It powers up as 0, so OSD reset keeps the loaded DIPs.
- `frame_tick` asserted for more than one cycle counts once per asserted cycle; the caller guarantees a single-cycle strobe.

## Configuration

- `ARCADE_INPUT_AUTOFIRE_EN` defined: autofire logic is built as described.
- Not defined: `af_mask` is ignored, masked bits pass through unchanged, and no autofire registers exist. Latency stays 2 cycles.

## Structure

- Package `arcade_input_pkg` holds:
  - bit-position constants `JB_RIGHT`=0 … `JB_F5`=8, `JB_START1`=9, `JB_START2`=10, `JB_COIN`=11;
  - `DIP_IOCTL_INDEX` = 8'd254;
  - the function `db_remap(db, odd)`.
- Sub-module `arcade_input_autofire`: one instance per player, generated under the macro. It holds `af_cnt`/`af_phase` and the masking.

## Test plan

- `PLAYERS`=2, `db_players`=1, DB0 = 16'h0021 (R + B) with db[10] = 1, USB0 = 32'h8: `joy_out[31:0]` has bits 0, 5, 10 and 11 set; `joy_out[63:32]` = 32'h8 after 2 cycles.
- Coin pressed for 1 cycle with `COIN_HOLD`=3: `coin_out` is high until the 3rd `frame_tick` after release, then goes low.
- `af_mask`=32'h10, F1 held, `AF_RATE`=2: bit 4 follows the frame pattern 1,1,0,0,1,1…; releasing F1 returns `af_phase` to 1.
- Writes of 8'hA5 to index 254, addr 2, and 8'hFF to addr 8 with `DIP_BYTES`=8: `dip[23:16]` = 8'hA5, other bytes unchanged, then pulse `reset_n` low: `dip` still holds 8'hA5.
- `reset_n` low while coin `hold_cnt`=2 and F1 autofire is in the off phase: all outputs are 0 in the next cycle; after release, held inputs reappear with a fresh coin pulse and `af_phase` = 1.
- Build without `ARCADE_INPUT_AUTOFIRE_EN`, F1 held with `af_mask`=32'h10: bit 4 stays constant 1 across 10 frame ticks.
